// File: rtl/div32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, 32 iterations
// per operation, with a single-cycle divide-by-zero shortcut.
module div32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  r_reg, r_next;
  logic [N-1:0]  q_reg, q_next;
  logic [N-1:0]  d_reg, d_next;
  logic [N-1:0]  quot_reg, quot_next;
  logic [N-1:0]  rem_reg, rem_next;
  logic          done_reg, done_next;
  logic          dbz_reg, dbz_next;

  // One restoring step. R never reaches 2^(N-1) before its final shift, so an
  // N-bit partial remainder loses nothing when shifted.
  logic [2*N-1:0] rq_shift;
  logic [N-1:0]   r_shift;
  logic [N:0]     trial;
  logic [N-1:0]   r_step;
  logic [N-1:0]   q_step;

  assign rq_shift = {r_reg, q_reg} << 1;
  assign r_shift  = rq_shift[2*N-1:N];
  assign trial    = {1'b0, r_shift} - {1'b0, d_reg};
  assign r_step   = trial[N] ? r_shift : trial[N-1:0];
  assign q_step   = rq_shift[N-1:0] | {{(N-1){1'b0}}, ~trial[N]};

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    done_next  = done_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          if (b != '0) begin
            state_next = RUN;
            r_next     = '0;
            q_next     = a;
            d_next     = b;
            count_next = '0;
            done_next  = 1'b0;
            dbz_next   = 1'b0;
          end else begin
            state_next = DONE;
            quot_next  = '1;
            rem_next   = a;
            done_next  = 1'b1;
            dbz_next   = 1'b1;
          end
        end
      end
      RUN: begin
        r_next     = r_step;
        q_next     = q_step;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(N - 1)) begin
          state_next = DONE;
          quot_next  = q_step;
          rem_next   = r_step;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign dbz       = dbz_reg;
  assign quotient  = quot_reg;
  assign remainder = rem_reg;

endmodule
